// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared types and constants for the ping-pong inter-layer buffer controller.
package pingpong_buf_ctrl_pkg;

  localparam int unsigned BANK_STATE_W = 2;

  typedef logic [BANK_STATE_W-1:0] bank_state_t;

  localparam bank_state_t BANK_EMPTY   = 2'd0;
  localparam bank_state_t BANK_WRITING = 2'd1;
  localparam bank_state_t BANK_FULL    = 2'd2;
  localparam bank_state_t BANK_READING = 2'd3;

  // SRAM control pins are active-low
  localparam logic SRAM_ON  = 1'b0;
  localparam logic SRAM_OFF = 1'b1;

endpackage

// File: rtl/pingpong_bank_state.sv
// Fill state and word count of one SRAM bank of the ping-pong pair.
module pingpong_bank_state
  import pingpong_buf_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_start,
  input  logic                wr_inc,
  input  logic                wr_fin,
  input  logic                rd_start,
  input  logic                rd_fin,
  output bank_state_t         state_q,
  output logic [ADDR_WIDTH:0] len_q,
  output logic                sat_c,
  output logic                full_q,
  output logic                empty_q
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  bank_state_t         state_d;
  logic [ADDR_WIDTH:0] len_d;
  logic                full_d;
  logic                empty_d;

  assign sat_c = (len_q == LEN_MAX);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      BANK_EMPTY: begin
        if (wr_start) begin
          state_d = BANK_WRITING;
          len_d   = '0;
        end
      end
      BANK_WRITING: begin
        if (wr_inc && !sat_c) len_d = len_q + LEN_W'(1);
        if (wr_fin) state_d = BANK_FULL;
      end
      BANK_FULL: begin
        if (rd_start) state_d = BANK_READING;
      end
      BANK_READING: begin
        if (rd_fin) state_d = BANK_EMPTY;
      end
      default: state_d = BANK_EMPTY;
    endcase
    // status flags track the state being entered so they line up with it
    full_d  = (state_d == BANK_FULL);
    empty_d = (state_d == BANK_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BANK_EMPTY;
      len_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong SRAM pair shared between a producer and a consumer layer:
// alternating bank grants, active-low SRAM strobes and status reporting.
module pingpong_buf_ctrl
  import pingpong_buf_ctrl_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  output logic                  wr_gnt,
  output logic                  wr_bank,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [IMG_WIDTH-1:0]  wr_data,
  input  logic                  wr_done,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH:0]   rd_len,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic [IMG_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic [1:0]            full,
  output logic [1:0]            empty,
  output logic                  err,
  output logic [1:0]            sram_cs_n,
  output logic [1:0]            sram_oe_n,
  output logic [1:0]            sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  output logic [IMG_WIDTH-1:0]  sram_wdata,
  input  logic [IMG_WIDTH-1:0]  sram_rdata0,
  input  logic [IMG_WIDTH-1:0]  sram_rdata1
);

  bank_state_t         bank_state [2];
  logic [ADDR_WIDTH:0] bank_len   [2];
  logic [1:0]          bank_sat;
  logic [1:0]          bank_full;
  logic [1:0]          bank_empty;

  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_gnt_q, wr_gnt_d;
  logic                rd_gnt_q, rd_gnt_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH:0] rd_len_q, rd_len_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_sel_q, rd_sel_d;
  logic                err_q, err_d;

  logic wr_ok_c, wr_fin_c, wr_start_c;
  logic rd_ok_c, rd_fin_c, rd_start_c;
  logic proto_err_c;

  logic [1:0] wr_start_b, wr_inc_b, wr_fin_b, rd_start_b, rd_fin_b;

  // Qualified strobes: anything outside a grant, or a write at saturation, is ignored
  always_comb begin
    wr_ok_c    = wr_en & wr_gnt_q & ~bank_sat[wr_bank_q];
    wr_fin_c   = wr_done & wr_gnt_q;
    rd_ok_c    = rd_en & rd_gnt_q;
    rd_fin_c   = rd_done & rd_gnt_q;
    wr_start_c = wr_req & ~wr_gnt_q & (bank_state[wr_ptr_q] == BANK_EMPTY);
    rd_start_c = rd_req & ~rd_gnt_q & (bank_state[rd_ptr_q] == BANK_FULL);
    proto_err_c = ((wr_en | wr_done) & ~wr_gnt_q)
                | ((rd_en | rd_done) & ~rd_gnt_q)
                | (wr_en & wr_gnt_q & bank_sat[wr_bank_q]);
  end

  always_comb begin
    wr_start_b = '0;
    wr_inc_b   = '0;
    wr_fin_b   = '0;
    rd_start_b = '0;
    rd_fin_b   = '0;
    wr_start_b[wr_ptr_q]  = wr_start_c;
    wr_inc_b[wr_bank_q]   = wr_ok_c;
    wr_fin_b[wr_bank_q]   = wr_fin_c;
    rd_start_b[rd_ptr_q]  = rd_start_c;
    rd_fin_b[rd_bank_q]   = rd_fin_c;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank_state #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_start (wr_start_b[b]),
      .wr_inc   (wr_inc_b[b]),
      .wr_fin   (wr_fin_b[b]),
      .rd_start (rd_start_b[b]),
      .rd_fin   (rd_fin_b[b]),
      .state_q  (bank_state[b]),
      .len_q    (bank_len[b]),
      .sat_c    (bank_sat[b]),
      .full_q   (bank_full[b]),
      .empty_q  (bank_empty[b])
    );
  end

  // Grant and pointer bookkeeping; the two sides never share a bank
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_gnt_d   = wr_gnt_q;
    rd_gnt_d   = rd_gnt_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    rd_len_d   = rd_len_q;
    rd_valid_d = rd_ok_c;
    rd_sel_d   = rd_sel_q;
    err_d      = err_q | proto_err_c;

    if (wr_start_c) begin
      wr_gnt_d  = 1'b1;
      wr_bank_d = wr_ptr_q;
    end else if (wr_fin_c) begin
      wr_gnt_d = 1'b0;
      wr_ptr_d = ~wr_ptr_q;
    end

    if (rd_start_c) begin
      rd_gnt_d  = 1'b1;
      rd_bank_d = rd_ptr_q;
      rd_len_d  = bank_len[rd_ptr_q];
    end else if (rd_fin_c) begin
      rd_gnt_d = 1'b0;
      rd_ptr_d = ~rd_ptr_q;
    end

    if (rd_ok_c) rd_sel_d = rd_bank_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      rd_gnt_q   <= 1'b0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_len_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_gnt_q   <= wr_gnt_d;
      rd_gnt_q   <= rd_gnt_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      rd_len_q   <= rd_len_d;
      rd_valid_q <= rd_valid_d;
      rd_sel_q   <= rd_sel_d;
      err_q      <= err_d;
    end
  end

  // SRAM strobes follow the qualified accesses in the same cycle
  always_comb begin
    sram_cs_n  = {2{SRAM_OFF}};
    sram_oe_n  = {2{SRAM_OFF}};
    sram_we_n  = {2{SRAM_OFF}};
    sram_addr0 = '0;
    sram_addr1 = '0;
    if (wr_ok_c) begin
      sram_cs_n[wr_bank_q] = SRAM_ON;
      sram_we_n[wr_bank_q] = SRAM_ON;
      if (wr_bank_q) sram_addr1 = wr_addr;
      else           sram_addr0 = wr_addr;
    end
    if (rd_ok_c) begin
      sram_cs_n[rd_bank_q] = SRAM_ON;
      sram_oe_n[rd_bank_q] = SRAM_ON;
      if (rd_bank_q) sram_addr1 = rd_addr;
      else           sram_addr0 = rd_addr;
    end
  end

  assign sram_wdata = wr_data;
  // SRAM read data arrives the cycle after rd_en; the registered select picks the bank
  assign rd_data    = rd_valid_q ? (rd_sel_q ? sram_rdata1 : sram_rdata0) : '0;

  assign wr_gnt   = wr_gnt_q;
  assign wr_bank  = wr_bank_q;
  assign rd_gnt   = rd_gnt_q;
  assign rd_bank  = rd_bank_q;
  assign rd_len   = rd_len_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign full     = bank_full;
  assign empty    = bank_empty;

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Randomized scoreboard bench for pingpong_buf_ctrl with behavioural SRAM and frame model.
module tb_pingpong_buf_ctrl;

  localparam int unsigned IW    = 16;
  localparam int unsigned AW    = 10;
  localparam int          DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0, wr_en = 1'b0, wr_done = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [IW-1:0] wr_data = '0;
  logic          rd_req = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_gnt, wr_bank, rd_gnt, rd_bank, rd_valid, err;
  logic [AW:0]   rd_len;
  logic [IW-1:0] rd_data, sram_wdata;
  logic [1:0]    full, empty, sram_cs_n, sram_oe_n, sram_we_n;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [IW-1:0] sram_rdata0 = '0;
  logic [IW-1:0] sram_rdata1 = '0;

  always #5 clk = ~clk;

  pingpong_buf_ctrl #(.IMG_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_bank(wr_bank), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_bank(rd_bank), .rd_len(rd_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .err(err),
    .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_addr0(sram_addr0), .sram_addr1(sram_addr1), .sram_wdata(sram_wdata),
    .sram_rdata0(sram_rdata0), .sram_rdata1(sram_rdata1)
  );

  // Synchronous SRAM pair: one-cycle read latency
  logic [IW-1:0] mem0 [DEPTH];
  logic [IW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (!sram_cs_n[0] && !sram_we_n[0]) mem0[sram_addr0] <= sram_wdata;
    if (!sram_cs_n[0] && !sram_oe_n[0]) sram_rdata0 <= mem0[sram_addr0];
    if (!sram_cs_n[1] && !sram_we_n[1]) mem1[sram_addr1] <= sram_wdata;
    if (!sram_cs_n[1] && !sram_oe_n[1]) sram_rdata1 <= mem1[sram_addr1];
  end

  // Reference model: frame contents per bank, bank = frame count mod 2
  logic [IW-1:0] exp_frame [2][DEPTH];
  int            exp_len [2];
  int            wr_frames, rd_frames;
  logic [IW-1:0] sb_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every delivered word must match the oldest outstanding read
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_valid_unexpected: got rd_data 0x%0h with nothing outstanding", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    {wr_req, wr_en, wr_done, rd_req, rd_en, rd_done} = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr_frames = 0;
    rd_frames = 0;
    exp_len[0] = 0;
    exp_len[1] = 0;
  endtask

  task automatic acquire_wr();
    int b;
    bit got;
    b = wr_frames % 2;
    got = 1'b0;
    wr_req = 1'b1;
    #1 check("wr_gnt_same_cycle", 32'(wr_gnt), 0);
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = wr_gnt;
    end
    check("wr_gnt_timeout", 32'(got), 1);
    check("wr_bank", 32'(wr_bank), 32'(b));
    wr_req = 1'b0;
    exp_len[b] = 0;
  endtask

  task automatic write_words(input int n, input bit fixed);
    int b;
    b = wr_frames % 2;
    for (int i = 0; i < n; i++) begin
      while (!fixed && $urandom_range(3) == 0) step();
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = fixed ? IW'(32'hA000 + 32'(i)) : IW'($urandom);
      #1 check("we_n_write", 32'(sram_we_n), (b == 1) ? 32'h1 : 32'h2);
      exp_frame[b][i] = wr_data;
      if (exp_len[b] < DEPTH) exp_len[b]++;
      step();
      wr_en = 1'b0;
    end
  endtask

  task automatic finish_wr();
    int b;
    b = wr_frames % 2;
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check("wr_gnt_after_done", 32'(wr_gnt), 0);
    check("full_after_wr_done", 32'(full[b]), 1);
    wr_frames++;
  endtask

  task automatic acquire_rd();
    int b;
    bit got;
    b = rd_frames % 2;
    got = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = rd_gnt;
    end
    check("rd_gnt_timeout", 32'(got), 1);
    check("rd_bank", 32'(rd_bank), 32'(b));
    check("rd_len", 32'(rd_len), 32'(exp_len[b]));
    rd_req = 1'b0;
  endtask

  task automatic read_words(input int n, input bit fixed);
    int b, a;
    b = rd_frames % 2;
    for (int i = 0; i < n; i++) begin
      while (!fixed && $urandom_range(3) == 0) step();
      a = fixed ? i : int'($urandom_range(exp_len[b] - 1));
      rd_en   = 1'b1;
      rd_addr = AW'(a);
      sb_q.push_back(exp_frame[b][a]);
      #1 check("oe_n_read", 32'(sram_oe_n), (b == 1) ? 32'h1 : 32'h2);
      step();
      rd_en = 1'b0;
      check("rd_valid_latency", 32'(rd_valid), 1);
    end
  endtask

  task automatic finish_rd();
    int b;
    b = rd_frames % 2;
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("rd_gnt_after_done", 32'(rd_gnt), 0);
    check("empty_after_rd_done", 32'(empty[b]), 1);
    rd_frames++;
  endtask

  initial begin
    int len, wcnt;
    bit got;

    // Reset values and a single fixed frame
    reset_dut();
    check("rst_empty", 32'(empty), 32'h3);
    check("rst_full", 32'(full), 0);
    check("rst_gnts", 32'({wr_gnt, rd_gnt, wr_bank, rd_bank}), 0);
    check("rst_rd", 32'({rd_valid, rd_data, rd_len}), 0);
    check("rst_err", 32'(err), 0);
    check("rst_sram_n", 32'({sram_cs_n, sram_oe_n, sram_we_n}), 32'h3F);
    acquire_wr();
    write_words(5, 1'b1);
    finish_wr();
    acquire_rd();
    read_words(5, 1'b1);
    finish_rd();
    step();
    check("single_full_end", 32'(full), 0);
    check("single_empty_end", 32'(empty), 32'h3);

    // Alternation over three frames
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      len = int'($urandom_range(8, 1));
      acquire_wr();
      write_words(len, 1'b0);
      finish_wr();
      acquire_rd();
      read_words(len, 1'b0);
      finish_rd();
    end

    // Back-pressure with both banks full
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      acquire_wr();
      write_words(int'($urandom_range(6, 1)), 1'b0);
      finish_wr();
    end
    wr_req = 1'b1;
    repeat (4) begin
      step();
      check("bp_wr_gnt", 32'(wr_gnt), 0);
      check("bp_full", 32'(full), 32'h3);
    end
    acquire_rd();
    finish_rd();
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      step();
      got = wr_gnt;
    end
    check("bp_regrant", 32'(got), 1);
    check("bp_regrant_bank", 32'(wr_bank), 0);
    wr_req = 1'b0;
    exp_len[0] = 0;
    write_words(3, 1'b0);
    finish_wr();
    for (int k = 0; k < 2; k++) begin
      acquire_rd();
      read_words(exp_len[rd_frames % 2], 1'b0);
      finish_rd();
    end

    // Concurrent write of bank 1 while reading bank 0
    reset_dut();
    acquire_wr();
    write_words(6, 1'b0);
    finish_wr();
    acquire_rd();
    acquire_wr();
    wcnt = 0;
    for (int c = 0; c < 16; c++) begin
      wr_en = 1'($urandom_range(1));
      rd_en = 1'($urandom_range(1));
      if (wr_en) begin
        wr_addr = AW'(wcnt);
        wr_data = IW'($urandom);
        exp_frame[1][wcnt] = wr_data;
      end
      if (rd_en) begin
        len = int'($urandom_range(exp_len[0] - 1));
        rd_addr = AW'(len);
        sb_q.push_back(exp_frame[0][len]);
      end
      #1;
      check("cc_we_n", 32'(sram_we_n), 32'({~wr_en, 1'b1}));
      check("cc_oe_n", 32'(sram_oe_n), 32'({1'b1, ~rd_en}));
      check("cc_cs_n", 32'(sram_cs_n), 32'({~wr_en, ~rd_en}));
      step();
      if (wr_en) wcnt++;
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
    wr_done = 1'b1;
    rd_done = 1'b1;
    step();
    wr_done = 1'b0;
    rd_done = 1'b0;
    check("cc_full", 32'(full), 32'h2);
    check("cc_empty", 32'(empty), 32'h1);
    check("cc_gnts", 32'({wr_gnt, rd_gnt}), 0);
    wr_frames = 2;
    rd_frames = 1;
    exp_len[1] = wcnt;
    if (wcnt > 0) begin
      acquire_rd();
      read_words(wcnt, 1'b0);
      finish_rd();
    end

    // Protocol errors: ungranted strobes are ignored but flagged
    reset_dut();
    wr_en = 1'b1;
    wr_addr = AW'(3);
    #1 check("perr_sram_n", 32'({sram_cs_n, sram_we_n}), 32'hF);
    step();
    wr_en = 1'b0;
    check("perr_err", 32'(err), 1);
    check("perr_state", 32'({full, empty, wr_gnt}), 32'h6);
    repeat (5) step();
    check("perr_sticky", 32'(err), 1);
    acquire_wr();
    reset_dut();
    check("perr_cleared", 32'(err), 0);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    check("perr_rd_done", 32'(err), 1);
    check("perr_rd_gnt", 32'(rd_gnt), 0);

    // Saturated frame: the extra write must be dropped and flagged
    reset_dut();
    acquire_wr();
    write_words(DEPTH, 1'b0);
    check("sat_no_err", 32'(err), 0);
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = ~exp_frame[0][0];
    #1 check("sat_we_n", 32'(sram_we_n), 32'h3);
    step();
    wr_en = 1'b0;
    check("sat_err", 32'(err), 1);
    finish_wr();
    acquire_rd();
    read_words(4, 1'b1);
    finish_rd();

    // Reset in the middle of a read
    reset_dut();
    acquire_wr();
    write_words(4, 1'b0);
    finish_wr();
    acquire_rd();
    rd_en = 1'b1;
    rd_addr = '0;
    step();
    check("mid_rd_valid_pre", 32'(rd_valid), 1);
    #1 rst = 1'b1;
    sb_q.delete();
    #1;
    check("mid_empty", 32'(empty), 32'h3);
    check("mid_full", 32'(full), 0);
    check("mid_gnts", 32'({wr_gnt, rd_gnt}), 0);
    check("mid_sram_n", 32'({sram_cs_n, sram_oe_n, sram_we_n}), 32'h3F);
    check("mid_rd_valid", 32'({rd_valid, rd_data}), 0);
    rd_en = 1'b0;
    reset_dut();

    step();
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pingpong_buf_ctrl.md
Name: pingpong_buf_ctrl

Overview:
Owns one ping-pong pair of inter-layer image SRAMs (bank 0 / bank 1) and shares it between a producer layer (writer) and a consumer layer (reader). Per-bank fill state: EMPTY, WRITING, FULL, READING. Grants banks in strict alternation, drives the active-low SRAM controls, and reports full/empty status and frame length to the layer controllers.

Parameters:
IMG_WIDTH, 16, data word width
ADDR_WIDTH, 10, SRAM address width; bank depth 2**ADDR_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_req  in  1  producer wants a bank (level)
wr_gnt  out  1  producer owns bank wr_bank
wr_bank  out  1  bank currently granted to producer
wr_en  in  1  write strobe
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  IMG_WIDTH  write data
wr_done  in  1  producer finished frame (1-cycle pulse)
rd_req  in  1  consumer wants a bank (level)
rd_gnt  out  1  consumer owns bank rd_bank
rd_bank  out  1  bank currently granted to consumer
rd_len  out  ADDR_WIDTH+1  words written into rd_bank
rd_en  in  1  read strobe
rd_addr  in  ADDR_WIDTH  read address
rd_done  in  1  consumer finished frame (1-cycle pulse)
rd_data  out  IMG_WIDTH  read data
rd_valid  out  1  rd_data valid
full  out  2  per-bank FULL
empty  out  2  per-bank EMPTY
err  out  1  sticky protocol-violation flag
sram_cs_n  out  2  per-bank chip select, active-low
sram_oe_n  out  2  per-bank output enable, active-low
sram_we_n  out  2  per-bank write enable, active-low
sram_addr0, sram_addr1  out  ADDR_WIDTH  per-bank address
sram_wdata  out  IMG_WIDTH  shared write data (= wr_data)
sram_rdata0, sram_rdata1  in  IMG_WIDTH  per-bank read data

Behaviour:
- Reset: both banks EMPTY; wr_ptr=rd_ptr=0; wr_gnt=rd_gnt=0; wr_bank=rd_bank=0; rd_len=0; rd_valid=0; rd_data=0; err=0; empty=2'b11; full=2'b00; all sram_*_n=1. Reset mid-frame aborts the frame; its contents are discarded.
- Write grant: on the clock edge where wr_req=1, wr_gnt=0 and bank[wr_ptr]==EMPTY: bank -> WRITING, wr_gnt=1, wr_bank=wr_ptr, len[wr_ptr]=0. Grant is asserted one cycle after the request at the earliest.
- While wr_gnt: each wr_en increments len[wr_bank], saturating at 2**ADDR_WIDTH. Combinationally: sram_cs_n[wr_bank]=0, sram_we_n[wr_bank]=0, and sram_addr of that bank = wr_addr.
- wr_done while wr_gnt: bank -> FULL, wr_gnt=0 and wr_ptr toggles on the next edge. A wr_en in the same cycle is still written and counted.
- Read grant: on the clock edge where rd_req=1, rd_gnt=0 and bank[rd_ptr]==FULL: bank -> READING, rd_gnt=1, rd_bank=rd_ptr, rd_len=len[rd_ptr]. A FULL set by wr_done at edge t is grantable at edge t+1 at the earliest.
- While rd_gnt: rd_en drives sram_cs_n[rd_bank]=0, sram_oe_n[rd_bank]=0, sram_addr of that bank = rd_addr. rd_valid=1 and rd_data = sram_rdata[rd_bank] one cycle later. The bank select is registered alongside rd_valid.
- rd_done while rd_gnt: bank -> EMPTY, rd_gnt=0 and rd_ptr toggles on the next edge. The final pending rd_valid is still delivered.
- Both sides can be active at once; they are always on different banks by construction. wr_done and rd_done in the same cycle are both honoured.
- Both banks FULL with wr_req high: wr_gnt stays 0 (back-pressure) until a bank becomes EMPTY. Both banks EMPTY with rd_req high: rd_gnt stays 0.
- err is set (sticky until reset) on any of:
  - wr_en or wr_done without wr_gnt;
  - rd_en or rd_done without rd_gnt;
  - wr_en at saturated len.
  The offending strobe drives no SRAM control and changes no state.
- full/empty are registered decodes of bank state.

Decomposition:
- Shared package: bank-state enum (EMPTY, WRITING, FULL, READING) and the SRAM active-low level constants.
- One natural sub-module: pingpong_bank_state. It holds one bank's state register and length counter, is instantiated twice, and the top level holds the pointers, grants and muxing.

Test Plan:
- Single frame: wr_req; write 5 words (addr 0..4, data 0xA000+i); wr_done; rd_req; read addr 0..4 -> wr_bank=0, rd_len=5, rd_data 0xA000..0xA004 each one cycle after rd_en, full=2'b00 and empty=2'b11 at end.
- Alternation: three back-to-back frames with interleaved reads -> wr_bank sequence 0,1,0 and rd_bank sequence 0,1,0; sram_we_n asserted only on the granted bank.
- Back-pressure: two frames written, no reads, wr_req held -> wr_gnt=0 and full=2'b11; rd_done on bank 0 -> wr_gnt=1 with wr_bank=0 within 2 cycles.
- Concurrency: write bank 1 while reading bank 0, then wr_done and rd_done in the same cycle -> bank 1 FULL, bank 0 EMPTY, no cross-bank SRAM strobes.
- Protocol error: wr_en with wr_gnt=0 -> err=1, all sram_we_n=1, state unchanged; err stays 1 until rst.
- Mid-frame reset: rst pulsed during READING of bank 0 -> immediately (asynchronously) empty=2'b11, grants 0, all sram_*_n=1, rd_valid=0.
